axi_rab_w_drain: RTL and testbench

Read-side consumer for the RAB's BRAM-backed W-beat buffer. While the address channel of a write awaits its translation result, its W beats accumulate in that buffer. This block pops beats in order and, per burst, either forwards them to the master W channel (translation hit) or silently consumes and discards them (miss or protection error), as directed by a queue of per-burst decisions.

---
 rtl/axi_rab_w_drain_pkg.sv | 30 +++
 rtl/axi_rab_w_drain_dec_fifo.sv | 73 +++++++
 rtl/axi_rab_w_drain.sv | 159 +++++++++++++++
 tb/tb_axi_rab_w_drain.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rab_w_drain_pkg.sv
// Shared definitions for the RAB W-beat drain: a small math helper package
// used for pointer sizing, and the drain's own types and constants.

package CfMath;

  // Ceiling log2; returns 0 for val <= 1.
  function automatic int log2(input int val);
    int res;
    res = 0;
    while ((1 << res) < val) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

package rab_w_drain_pkg;

  // Per-burst handling state of the drain.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } drain_state_e;

  // Width of the saturating dropped-burst counter.
  localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/axi_rab_w_drain_dec_fifo.sv
// Register-based 1-bit FIFO holding per-burst forward/drop decisions.
// A flush empties it in one cycle and discards any same-cycle push or pop.

module rab_dec_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int PTR_W = CfMath::log2(DEPTH);
  localparam int CNT_W = CfMath::log2(DEPTH) + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rd_ptr];

  // A push is refused while full even if a pop frees a slot this cycle.
  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Decision storage, written on accepted pushes.
  // NOTE: storage is deliberately not reset; the occupancy counter guarantees
  // no slot is read before it is written, so a reset here buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/axi_rab_w_drain.sv
// Drains the RAB W-beat buffer in order: each burst is either forwarded to
// the master W channel or consumed silently, as decided by a queue of
// per-burst verdicts from the translation path. The datapath is purely
// combinational; only the decision queue, FSM, flush latch and drop counter
// hold state.

module axi_rab_w_drain
  import rab_w_drain_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int DEC_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush_i,
  input  logic [AXI_DATA_WIDTH-1:0]   buf_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] buf_strb_i,
  input  logic                        buf_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   buf_user_i,
  input  logic                        buf_valid_i,
  output logic                        buf_ready_o,
  input  logic                        dec_valid_i,
  input  logic                        dec_drop_i,
  output logic                        dec_ready_o,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                        m_wlast_o,
  output logic [AXI_USER_WIDTH-1:0]   m_wuser_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  output logic [DROP_CNT_WIDTH-1:0]   drop_cnt_o,
  output logic                        busy_o
);

  drain_state_e r_state;
  drain_state_e w_state_nxt;

  logic                      r_flush_pend;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic w_dec_head;
  logic w_dec_empty;
  logic w_dec_full;
  logic w_dec_pop;

  logic w_fwd_stall;
  logic w_flush_apply;
  logic w_seek;
  logic w_drop_inc;
  logic w_buf_ready;
  logic w_m_wvalid;

  rab_dec_fifo #(
    .DEPTH (DEC_DEPTH)
  ) u_dec_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (w_flush_apply),
    .push_i  (dec_valid_i),
    .data_i  (dec_drop_i),
    .pop_i   (w_dec_pop),
    .data_o  (w_dec_head),
    .empty_o (w_dec_empty),
    .full_o  (w_dec_full)
  );

  // A presented-but-unaccepted forward beat must not lose VALID, so a flush
  // is held back until that beat's handshake.
  assign w_fwd_stall   = (r_state == FWD) && buf_valid_i && !m_wready_i;
  assign w_flush_apply = (flush_i || r_flush_pend) && !w_fwd_stall;

  // Next-state, buffer pop and master-valid decode.
  // NOTE: every signal gets a default before the case; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dec_pop   = 1'b0;
    w_buf_ready = 1'b0;
    w_m_wvalid  = 1'b0;
    w_seek      = 1'b0;
    w_drop_inc  = 1'b0;

    case (r_state)
      IDLE: begin
        w_seek = 1'b1;
      end
      FWD: begin
        w_m_wvalid  = buf_valid_i;
        w_buf_ready = m_wready_i;
        w_seek      = buf_valid_i && m_wready_i && buf_last_i;
      end
      DROP: begin
        w_buf_ready = 1'b1;
        w_seek      = buf_valid_i && buf_last_i;
        w_drop_inc  = w_seek;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Idle or end of burst: take the next verdict without a bubble if queued.
    if (w_seek) begin
      if (!w_dec_empty) begin
        w_dec_pop   = 1'b1;
        w_state_nxt = w_dec_head ? DROP : FWD;
      end else begin
        w_state_nxt = IDLE;
      end
    end

    if (w_flush_apply) begin
      w_state_nxt = IDLE;
      w_dec_pop   = 1'b0;
      w_drop_inc  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Remember a flush that arrived while a forward beat was stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush_apply) begin
      r_flush_pend <= 1'b0;
    end else if (flush_i) begin
      r_flush_pend <= 1'b1;
    end
  end

  // Saturating count of discarded bursts; survives flushes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
    end else if (w_drop_inc && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  assign buf_ready_o = w_buf_ready;
  assign m_wvalid_o  = w_m_wvalid;
  assign m_wdata_o   = buf_data_i;
  assign m_wstrb_o   = buf_strb_i;
  assign m_wlast_o   = buf_last_i;
  assign m_wuser_o   = buf_user_i;
  assign dec_ready_o = !w_dec_full;
  assign drop_cnt_o  = r_drop_cnt;
  assign busy_o      = (r_state != IDLE) || !w_dec_empty;

endmodule

// File: tb/tb_axi_rab_w_drain.sv
// Self-checking bench for axi_rab_w_drain. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well before the next
// rising edge.

module tb_axi_rab_w_drain;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [5:0]  user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [63:0] buf_data;
  logic [7:0]  buf_strb;
  logic        buf_last;
  logic [5:0]  buf_user;
  logic        buf_valid;
  logic        buf_ready;
  logic        dec_valid;
  logic        dec_drop;
  logic        dec_ready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic [5:0]  m_wuser;
  logic        m_wvalid;
  logic        m_wready;
  logic [15:0] drop_cnt;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  axi_rab_w_drain #(
    .AXI_DATA_WIDTH (64),
    .AXI_USER_WIDTH (6),
    .DEC_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (flush),
    .buf_data_i  (buf_data),
    .buf_strb_i  (buf_strb),
    .buf_last_i  (buf_last),
    .buf_user_i  (buf_user),
    .buf_valid_i (buf_valid),
    .buf_ready_o (buf_ready),
    .dec_valid_i (dec_valid),
    .dec_drop_i  (dec_drop),
    .dec_ready_o (dec_ready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_wlast_o   (m_wlast),
    .m_wuser_o   (m_wuser),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (m_wready),
    .drop_cnt_o  (drop_cnt),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.strb = 8'($urandom);
    b.last = last;
    b.user = 6'($urandom);
    return b;
  endfunction

  task automatic put_beat(input beat_t b);
    buf_data = b.data;
    buf_strb = b.strb;
    buf_last = b.last;
    buf_user = b.user;
  endtask

  task automatic drive_idle();
    flush     = 1'b0;
    dec_valid = 1'b0;
    dec_drop  = 1'b0;
    buf_valid = 1'b0;
    put_beat('0);
    m_wready  = 1'b0;
  endtask

  // Leaves the bench aligned just after a falling edge with reset released.
  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (dec_ready !== 1'b1) $display("FAIL reset_dec_ready: got %b want 1", dec_ready);
    else n_pass++;
    n_checks++;
    if (buf_ready !== 1'b0) $display("FAIL reset_buf_ready: got %b want 0", buf_ready);
    else n_pass++;
    n_checks++;
    if (m_wvalid !== 1'b0) $display("FAIL reset_m_wvalid: got %b want 0", m_wvalid);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single_forward();
    beat_t b[4];
    do_reset();
    for (int k = 0; k < 4; k++) b[k] = rand_beat(k == 3);
    dec_valid = 1'b1; dec_drop = 1'b0; buf_valid = 1'b1; put_beat(b[0]); m_wready = 1'b1;
    #1;
    n_checks++;
    if (m_wvalid !== 1'b0) $display("FAIL fwd_t0_valid: got %b want 0", m_wvalid);
    else n_pass++;
    @(negedge clk);
    dec_valid = 1'b0;
    #1;
    n_checks++;
    if ({m_wvalid, busy} !== 2'b01) $display("FAIL fwd_t1_valid_busy: got %b want 01", {m_wvalid, busy});
    else n_pass++;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      put_beat(b[k]);
      #1;
      n_checks++;
      if ({m_wvalid, buf_ready, m_wlast, m_wdata} !== {2'b11, b[k].last, b[k].data})
        $display("FAIL fwd_beat%0d: got v=%b r=%b l=%b d=%h want v=1 r=1 l=%b d=%h",
                 k, m_wvalid, buf_ready, m_wlast, m_wdata, b[k].last, b[k].data);
      else n_pass++;
      @(negedge clk);
    end
    buf_valid = 1'b0;
    #1;
    n_checks++;
    if ({m_wvalid, busy, drop_cnt} !== {2'b00, 16'h0})
      $display("FAIL fwd_end: got v=%b busy=%b cnt=%h want 0 0 0000", m_wvalid, busy, drop_cnt);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_drop_then_forward();
    beat_t b[5];
    do_reset();
    for (int k = 0; k < 5; k++) b[k] = rand_beat(k == 1 || k == 4);
    dec_valid = 1'b1; dec_drop = 1'b1; buf_valid = 1'b1; put_beat(b[0]); m_wready = 1'b1;
    #1;
    n_checks++;
    if (buf_ready !== 1'b0) $display("FAIL b2b_t0_buf_ready: got %b want 0", buf_ready);
    else n_pass++;
    @(negedge clk);
    dec_drop = 1'b0;
    #1;
    @(negedge clk);
    dec_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      put_beat(b[k]);
      #1;
      n_checks++;
      if ({m_wvalid, buf_ready} !== 2'b01)
        $display("FAIL b2b_drop_beat%0d: got v=%b r=%b want v=0 r=1", k, m_wvalid, buf_ready);
      else n_pass++;
      @(negedge clk);
    end
    for (int k = 2; k < 5; k++) begin
      put_beat(b[k]);
      #1;
      n_checks++;
      if ({m_wvalid, m_wlast, m_wdata, drop_cnt} !== {1'b1, b[k].last, b[k].data, 16'h1})
        $display("FAIL b2b_fwd_beat%0d: got v=%b l=%b d=%h cnt=%h want v=1 l=%b d=%h cnt=0001",
                 k, m_wvalid, m_wlast, m_wdata, drop_cnt, b[k].last, b[k].data);
      else n_pass++;
      @(negedge clk);
    end
    buf_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, drop_cnt} !== {1'b0, 16'h1}) $display("FAIL b2b_end: got busy=%b cnt=%h want 0 0001", busy, drop_cnt);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure_flush();
    beat_t b0;
    beat_t b1;
    do_reset();
    b0 = rand_beat(1'b0);
    b1 = rand_beat(1'b1);
    dec_valid = 1'b1; dec_drop = 1'b0; buf_valid = 1'b1; put_beat(b0); m_wready = 1'b0;
    #1;
    @(negedge clk);
    dec_drop = 1'b1;
    #1;
    @(negedge clk);
    dec_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      flush = (s == 1);
      #1;
      n_checks++;
      if ({m_wvalid, buf_ready, busy, m_wdata} !== {3'b101, b0.data})
        $display("FAIL bp_stall%0d: got v=%b r=%b busy=%b d=%h want v=1 r=0 busy=1 d=%h",
                 s, m_wvalid, buf_ready, busy, m_wdata, b0.data);
      else n_pass++;
      @(negedge clk);
    end
    flush = 1'b0;
    m_wready = 1'b1;
    #1;
    n_checks++;
    if ({m_wvalid, buf_ready, m_wdata} !== {2'b11, b0.data})
      $display("FAIL bp_handshake: got v=%b r=%b d=%h want v=1 r=1 d=%h", m_wvalid, buf_ready, m_wdata, b0.data);
    else n_pass++;
    @(negedge clk);
    put_beat(b1);
    #1;
    n_checks++;
    if ({m_wvalid, busy, drop_cnt} !== {2'b00, 16'h0})
      $display("FAIL bp_flushed: got v=%b busy=%b cnt=%h want 0 0 0000", m_wvalid, busy, drop_cnt);
    else n_pass++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_queue_full();
    bit d[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int fwd = 0;
    do_reset();
    m_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dec_valid = 1'b1; dec_drop = d[i];
      #1;
      n_checks++;
      if (dec_ready !== 1'b1) $display("FAIL qf_push%0d_ready: got %b want 1", i, dec_ready);
      else n_pass++;
      @(negedge clk);
    end
    dec_drop = 1'b0;
    #1;
    n_checks++;
    if (dec_ready !== 1'b0) $display("FAIL qf_full_ready: got %b want 0", dec_ready);
    else n_pass++;
    @(negedge clk);
    buf_valid = 1'b1;
    put_beat(rand_beat(1'b1));
    #1;
    n_checks++;
    if ({dec_ready, m_wvalid} !== 2'b01) $display("FAIL qf_pop_cycle: got ready=%b v=%b want 0 1", dec_ready, m_wvalid);
    else n_pass++;
    if (m_wvalid && m_wready) fwd++;
    @(negedge clk);
    dec_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put_beat(rand_beat(1'b1));
      #1;
      if (i == 0) begin
        n_checks++;
        if (dec_ready !== 1'b1) $display("FAIL qf_after_pop_ready: got %b want 1", dec_ready);
        else n_pass++;
      end
      if (m_wvalid && m_wready) fwd++;
      @(negedge clk);
    end
    buf_valid = 1'b0;
    #1;
    n_checks++;
    if (fwd !== 2 || drop_cnt !== 16'd3 || busy !== 1'b0)
      $display("FAIL qf_drain: got fwd=%0d cnt=%0d busy=%b want fwd=2 cnt=3 busy=0", fwd, drop_cnt, busy);
    else n_pass++;
    @(negedge clk);
  endtask

  // Random bursts and verdicts; the reference is simply "forwarded beats are
  // the beats of the non-dropped bursts, in order; drops count the rest".
  task automatic test_random();
    beat_t beats[$];
    beat_t exp_fwd[$];
    bit    decs[$];
    int    exp_drops = 0;
    int    cyc = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int len;
      bit d;
      len = $urandom_range(1, 4);
      d = 1'($urandom_range(0, 1));
      decs.push_back(d);
      if (d) exp_drops++;
      for (int k = 0; k < len; k++) begin
        beat_t b;
        b = rand_beat(k == len - 1);
        beats.push_back(b);
        if (!d) exp_fwd.push_back(b);
      end
    end
    while ((beats.size() > 0 || decs.size() > 0) && cyc < 4000) begin
      dec_valid = (decs.size() > 0) && ($urandom_range(0, 3) != 0);
      dec_drop  = (decs.size() > 0) ? decs[0] : 1'b0;
      buf_valid = (beats.size() > 0) && ($urandom_range(0, 4) != 0);
      if (beats.size() > 0) put_beat(beats[0]);
      else put_beat('0);
      m_wready  = ($urandom_range(0, 3) != 0);
      #1;
      if (m_wvalid) begin
        n_checks++;
        if ({buf_valid, m_wdata, m_wstrb, m_wlast, m_wuser} !== {1'b1, buf_data, buf_strb, buf_last, buf_user})
          $display("FAIL rnd_passthrough cyc%0d: got bv=%b d=%h want bv=1 d=%h", cyc, buf_valid, m_wdata, buf_data);
        else n_pass++;
      end
      if (m_wvalid && m_wready) begin
        n_checks++;
        if (exp_fwd.size() == 0) begin
          $display("FAIL rnd_extra_beat cyc%0d: got d=%h want none", cyc, m_wdata);
        end else begin
          if ({m_wdata, m_wstrb, m_wlast, m_wuser} !== exp_fwd[0])
            $display("FAIL rnd_beat cyc%0d: got %h want %h", cyc, {m_wdata, m_wstrb, m_wlast, m_wuser}, exp_fwd[0]);
          else n_pass++;
          void'(exp_fwd.pop_front());
        end
      end
      if (dec_valid && dec_ready) void'(decs.pop_front());
      if (buf_valid && buf_ready) void'(beats.pop_front());
      @(negedge clk);
      cyc++;
    end
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (cyc >= 4000) $display("FAIL rnd_timeout: got %0d cycles want < 4000", cyc);
    else n_pass++;
    n_checks++;
    if (exp_fwd.size() != 0) $display("FAIL rnd_missing_beats: got %0d left want 0", exp_fwd.size());
    else n_pass++;
    n_checks++;
    if ({busy, drop_cnt} !== {1'b0, 16'(exp_drops)})
      $display("FAIL rnd_drops: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, drop_cnt, exp_drops);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    beat_t a;
    beat_t c;
    beat_t b[4];
    do_reset();
    a = rand_beat(1'b1);
    c = rand_beat(1'b1);
    for (int k = 0; k < 4; k++) b[k] = rand_beat(k == 3);
    m_wready = 1'b1;
    dec_valid = 1'b1; dec_drop = 1'b1; buf_valid = 1'b1; put_beat(a);
    #1;
    @(negedge clk);
    dec_drop = 1'b0;
    #1;
    @(negedge clk);
    dec_valid = 1'b0;
    #1;
    n_checks++;
    if ({m_wvalid, buf_ready} !== 2'b01) $display("FAIL rmb_drop: got v=%b r=%b want 0 1", m_wvalid, buf_ready);
    else n_pass++;
    @(negedge clk);
    put_beat(b[0]);
    #1;
    @(negedge clk);
    put_beat(b[1]);
    #1;
    n_checks++;
    if ({m_wvalid, m_wdata, drop_cnt} !== {1'b1, b[1].data, 16'h1})
      $display("FAIL rmb_beat2: got v=%b d=%h cnt=%h want v=1 d=%h cnt=0001", m_wvalid, m_wdata, drop_cnt, b[1].data);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m_wvalid, buf_ready, dec_ready, busy, drop_cnt} !== {4'b0010, 16'h0})
      $display("FAIL rmb_async: got v=%b r=%b dr=%b busy=%b cnt=%h want 0 0 1 0 0000",
               m_wvalid, buf_ready, dec_ready, busy, drop_cnt);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    dec_valid = 1'b1; dec_drop = 1'b0; put_beat(c);
    #1;
    @(negedge clk);
    dec_valid = 1'b0;
    #1;
    n_checks++;
    if (m_wvalid !== 1'b0) $display("FAIL rmb_new_t1: got v=%b want 0", m_wvalid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({m_wvalid, m_wlast, m_wdata} !== {2'b11, c.data})
      $display("FAIL rmb_new_beat: got v=%b l=%b d=%h want v=1 l=1 d=%h", m_wvalid, m_wlast, m_wdata, c.data);
    else n_pass++;
    @(negedge clk);
    buf_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rmb_new_end: got busy=%b want 0", busy);
    else n_pass++;
    @(negedge clk);
  endtask

  // Continuous single-beat drop bursts; every consumed beat is one burst.
  task automatic test_saturation();
    int drops = 0;
    int cyc = 0;
    int exp;
    do_reset();
    dec_valid = 1'b1; dec_drop = 1'b1; buf_valid = 1'b1; put_beat(rand_beat(1'b1)); m_wready = 1'b1;
    while (drops < 65537 && cyc < 70000) begin
      #1;
      if (buf_valid && buf_ready && !m_wvalid) drops++;
      @(negedge clk);
      cyc++;
      exp = (drops > 65535) ? 65535 : drops;
      if ((cyc % 16384) == 0 || drops == 65535) begin
        n_checks++;
        if (drop_cnt !== 16'(exp)) $display("FAIL sat_progress drops=%0d: got %0d want %0d", drops, drop_cnt, exp);
        else n_pass++;
      end
    end
    drive_idle();
    n_checks++;
    if (cyc >= 70000) $display("FAIL sat_timeout: got %0d cycles want < 70000", cyc);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 16'hFFFF) $display("FAIL sat_final: got %h want ffff", drop_cnt);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    drive_idle();
    test_reset();
    test_single_forward();
    test_drop_then_forward();
    test_backpressure_flush();
    test_queue_full();
    test_random();
    test_reset_mid_burst();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
